// File: rtl/adc_seq_scheduler_if.sv
// Requester / ADC-reader bundle for adc_seq_scheduler.
// The slave modport is the scheduler side; master is the requester and reader side.
interface adc_seq_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] req_ch;
    logic [N_REQ-1:0]   grant;
    logic               frame_strobe;
    logic [2:0]         ret_ch;
    logic [15:0]        data0_in;
    logic [15:0]        data1_in;
    logic [2:0]         next_ch;
    logic               rsp_valid;
    logic [IDW-1:0]     rsp_id;
    logic [2:0]         rsp_ch;
    logic [15:0]        rsp_data0;
    logic [15:0]        rsp_data1;
    logic               rsp_err;
    logic [15:0]        err_cnt;

    modport master (
        output req, req_ch, frame_strobe, ret_ch, data0_in, data1_in,
        input  grant, next_ch, rsp_valid, rsp_id, rsp_ch, rsp_data0, rsp_data1,
               rsp_err, err_cnt
    );

    modport slave (
        input  req, req_ch, frame_strobe, ret_ch, data0_in, data1_in,
        output grant, next_ch, rsp_valid, rsp_id, rsp_ch, rsp_data0, rsp_data1,
               rsp_err, err_cnt
    );
endinterface

// File: rtl/adc_seq_scheduler.sv
// Round-robin channel scheduler for the dual LTC2335-16 stream with a PIPE-deep tag pipeline.
// Define ADC_SCHED_ERRCNT_EN to build the saturating channel-mismatch counter.
module adc_seq_scheduler #(
    parameter int         N_REQ   = 4,
    parameter int         PIPE    = 2,
    parameter logic [2:0] IDLE_CH = 3'd0
) (
    input logic               clk,
    input logic               rst,
    adc_seq_scheduler_if.slave bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic [2:0]     ch;
    } tag_t;

    logic [IDW-1:0]   ptr;
    tag_t             pipe [PIPE];
    tag_t             push, pop;
    logic             found;
    logic [IDW-1:0]   win, cand;
    logic [2:0]       win_ch;
    int               idx;

    logic [N_REQ-1:0] grant_q;
    logic [2:0]       next_ch_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [2:0]       rsp_ch_q;
    logic [15:0]      rsp_data0_q, rsp_data1_q;
    logic             rsp_err_q;

    // First pending request at or after ptr, wrapping at N_REQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDW'(idx);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_ch   = bus.req_ch[3*int'(win) +: 3];
        push     = '{vld: found, id: win, ch: win_ch};
        pop      = pipe[PIPE-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            grant_q     <= '0;
            next_ch_q   <= IDLE_CH;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_ch_q    <= '0;
            rsp_data0_q <= '0;
            rsp_data1_q <= '0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < PIPE; i++) pipe[i] <= '0;
        end else begin
            grant_q     <= '0;
            rsp_valid_q <= 1'b0;
            if (bus.frame_strobe) begin
                if (found) begin
                    grant_q   <= N_REQ'(1) << win;
                    next_ch_q <= win_ch;
                    ptr       <= (win == IDW'(N_REQ-1)) ? '0 : win + 1'b1;
                end else begin
                    next_ch_q <= IDLE_CH;
                end
                pipe[0] <= push;
                for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
                // Data fields only move on an owned frame; idle frames are dropped.
                if (pop.vld) begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= pop.id;
                    rsp_ch_q    <= pop.ch;
                    rsp_data0_q <= bus.data0_in;
                    rsp_data1_q <= bus.data1_in;
                    rsp_err_q   <= (bus.ret_ch != pop.ch);
                end
            end
        end
    end

`ifdef ADC_SCHED_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= '0;
        else if (bus.frame_strobe && pop.vld && (bus.ret_ch != pop.ch) && (err_cnt_q != 16'hFFFF))
            err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 16'h0000;
`endif

    assign bus.grant     = grant_q;
    assign bus.next_ch   = next_ch_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_ch    = rsp_ch_q;
    assign bus.rsp_data0 = rsp_data0_q;
    assign bus.rsp_data1 = rsp_data1_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_adc_seq_scheduler.sv
// Directed bench for adc_seq_scheduler (N_REQ=4, PIPE=2, IDLE_CH=0).
module tb_adc_seq_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    adc_seq_scheduler_if #(.N_REQ(4)) b ();

    adc_seq_scheduler #(.N_REQ(4), .PIPE(2), .IDLE_CH(3'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic strobe();
        b.frame_strobe = 1'b1;
        @(posedge clk);
        #1 b.frame_strobe = 1'b0;
    endtask

    task automatic set_ret(input logic [2:0] ch, input logic [15:0] d0, input logic [15:0] d1);
        b.ret_ch   = ch;
        b.data0_in = d0;
        b.data1_in = d1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        b.req = '0; b.req_ch = '0; b.frame_strobe = 1'b0;
        set_ret(3'd0, 16'h0, 16'h0);
        do_reset();

        // reset state
        check("rst_grant", 32'(b.grant), 32'h0);
        check("rst_next_ch", 32'(b.next_ch), 32'h0);
        check("rst_rsp_valid", 32'(b.rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(b.rsp_id), 32'h0);
        check("rst_rsp_data0", 32'(b.rsp_data0), 32'h0);
        check("rst_rsp_err", 32'(b.rsp_err), 32'h0);
        check("rst_err_cnt", 32'(b.err_cnt), 32'h0);

        // idle strobes
        for (int k = 0; k < 5; k++) begin
            strobe();
            check("idle_next_ch", 32'(b.next_ch), 32'h0);
            check("idle_grant", 32'(b.grant), 32'h0);
            check("idle_rsp_valid", 32'(b.rsp_valid), 32'h0);
        end

        // single request on requester 2, channel 5
        b.req = 4'b0100; b.req_ch = 12'(5) << 6;
        strobe();
        check("single_grant", 32'(b.grant), 32'h4);
        check("single_next_ch", 32'(b.next_ch), 32'h5);
        b.req = '0;
        @(posedge clk); #1;
        check("single_grant_pulse", 32'(b.grant), 32'h0);
        strobe();
        check("single_gap_grant", 32'(b.grant), 32'h0);
        check("single_gap_next_ch", 32'(b.next_ch), 32'h0);
        check("single_gap_valid", 32'(b.rsp_valid), 32'h0);
        set_ret(3'd5, 16'h1234, 16'hABCD);
        strobe();
        check("single_rsp_valid", 32'(b.rsp_valid), 32'h1);
        check("single_rsp_id", 32'(b.rsp_id), 32'h2);
        check("single_rsp_ch", 32'(b.rsp_ch), 32'h5);
        check("single_rsp_data0", 32'(b.rsp_data0), 32'h1234);
        check("single_rsp_data1", 32'(b.rsp_data1), 32'hABCD);
        check("single_rsp_err", 32'(b.rsp_err), 32'h0);
        @(posedge clk); #1;
        check("single_rsp_pulse", 32'(b.rsp_valid), 32'h0);
        check("single_data_hold", 32'(b.rsp_data0), 32'h1234);

        // all four requesting, back-to-back strobes, strict rotation
        do_reset();
        b.req = 4'b1111;
        b.req_ch = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int k = 0; k < 10; k++) begin
            if (k == 8) b.req = '0;
            if (k >= 2) set_ret(3'(((k-2) % 4) + 1), 16'(16'h1000 + k), 16'(16'h2000 + k));
            strobe();
            if (k < 8) begin
                check("rr_grant", 32'(b.grant), 32'(1 << (k % 4)));
                check("rr_next_ch", 32'(b.next_ch), 32'((k % 4) + 1));
            end else begin
                check("rr_drain_grant", 32'(b.grant), 32'h0);
                check("rr_drain_next_ch", 32'(b.next_ch), 32'h0);
            end
            check("rr_rsp_valid", 32'(b.rsp_valid), (k >= 2) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                check("rr_rsp_id", 32'(b.rsp_id), 32'((k-2) % 4));
                check("rr_rsp_ch", 32'(b.rsp_ch), 32'(((k-2) % 4) + 1));
                check("rr_rsp_data0", 32'(b.rsp_data0), 32'(16'h1000 + k));
                check("rr_rsp_data1", 32'(b.rsp_data1), 32'(16'h2000 + k));
                check("rr_rsp_err", 32'(b.rsp_err), 32'h0);
            end
        end

        // channel mismatch: ask for 3, ADC reports 6
        b.req = 4'b0001; b.req_ch = 12'd3;
        strobe();
        check("mm_grant", 32'(b.grant), 32'h1);
        check("mm_next_ch", 32'(b.next_ch), 32'h3);
        b.req = '0;
        strobe();
        set_ret(3'd6, 16'h5555, 16'h6666);
        strobe();
        check("mm_rsp_valid", 32'(b.rsp_valid), 32'h1);
        check("mm_rsp_id", 32'(b.rsp_id), 32'h0);
        check("mm_rsp_ch", 32'(b.rsp_ch), 32'h3);
        check("mm_rsp_err", 32'(b.rsp_err), 32'h1);
`ifdef ADC_SCHED_ERRCNT_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        check("mm_err_cnt", 32'(b.err_cnt), 32'(exp_cnt));

        // drive the counter into saturation with a permanently mismatching requester
        b.req = 4'b0001;
        for (int k = 0; k < 65540; k++) strobe();
`ifdef ADC_SCHED_ERRCNT_EN
        exp_cnt = 16'hFFFF;
`else
        exp_cnt = 16'h0;
`endif
        check("sat_err_cnt", 32'(b.err_cnt), 32'(exp_cnt));
        b.req = '0;
        strobe(); strobe();
        check("sat_hold_err_cnt", 32'(b.err_cnt), 32'(exp_cnt));
        check("sat_rsp_err", 32'(b.rsp_err), 32'h1);
        check("sat_rsp_valid", 32'(b.rsp_valid), 32'h1);

        // reset coincident with a strobe while two tags are in flight
        do_reset();
        b.req = 4'b0110; b.req_ch = {3'd0, 3'd7, 3'd2, 3'd0};
        strobe();
        check("fl_grant0", 32'(b.grant), 32'h2);
        strobe();
        check("fl_grant1", 32'(b.grant), 32'h4);
        b.req = '0;
        set_ret(3'd2, 16'h7777, 16'h8888);
        rst = 1'b1; b.frame_strobe = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; b.frame_strobe = 1'b0;
        check("rs_grant", 32'(b.grant), 32'h0);
        check("rs_next_ch", 32'(b.next_ch), 32'h0);
        check("rs_rsp_valid", 32'(b.rsp_valid), 32'h0);
        check("rs_rsp_data0", 32'(b.rsp_data0), 32'h0);
        check("rs_err_cnt", 32'(b.err_cnt), 32'h0);
        for (int k = 0; k < 2; k++) begin
            strobe();
            check("rs_flush_valid", 32'(b.rsp_valid), 32'h0);
        end
        b.req = 4'b1001; b.req_ch = {3'd6, 3'd0, 3'd0, 3'd1};
        strobe();
        check("rs_ptr_zero", 32'(b.grant), 32'h1);
        check("rs_ptr_next_ch", 32'(b.next_ch), 32'h1);

        // request raised and withdrawn between strobes
        b.req = '0;
        strobe();
        check("cancel_pre_next_ch", 32'(b.next_ch), 32'h0);
        b.req = 4'b0010; b.req_ch = 12'(5) << 3;
        @(posedge clk); #1;
        check("cancel_no_early_grant", 32'(b.grant), 32'h0);
        b.req = '0;
        strobe();
        check("cancel_grant", 32'(b.grant), 32'h0);
        check("cancel_next_ch", 32'(b.next_ch), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
